// File: rtl/m_fetch_ctrl_if.sv
// Fetch-to-MMU request/response channel; master is the fetch controller, slave is the MMU.
interface m_fetch_ctrl_if;
    localparam int unsigned XLEN = 32;

    logic            i_req;
    logic [XLEN-1:0] i_vaddr;
    logic            i_kill;
    logic            i_ack;
    logic [XLEN-1:0] i_paddr;

    modport master (
        output i_req,
        output i_vaddr,
        output i_kill,
        input  i_ack,
        input  i_paddr
    );

    modport slave (
        input  i_req,
        input  i_vaddr,
        input  i_kill,
        output i_ack,
        output i_paddr
    );
endinterface

// File: rtl/m_fetch_ctrl.sv
// Instruction fetch controller: one outstanding MMU request, kill/redirect handling, decode hold.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt_o / kill_cnt_o performance counters.
module m_fetch_ctrl (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc_addr_in,
    input  logic                if_stall_in,
    input  logic                csr_pc_req_in,
    input  logic                exe_pc_req_in,
    m_fetch_ctrl_if.master      mmu,
    output logic                pc_advance_o,
    output logic                instr_valid_o,
    output logic [31:0]         instruction_o,
    output logic [31:0]         instr_pc_o,
    input  logic                id_ready_in
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt_o,
    output logic [31:0]         kill_cnt_o
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              kill;
    logic              req;

    // Request issue is same-cycle so the PC register can step while the MMU samples the address.
    assign kill         = csr_pc_req_in | exe_pc_req_in;
    assign req          = !rst && (state_q == IDLE) && !if_stall_in && !kill;
    assign mmu.i_kill   = kill;
    assign mmu.i_req    = req;
    assign mmu.i_vaddr  = req ? pc_addr_in : XLEN'(0);
    assign pc_advance_o = req;

    assign instr_valid_o = valid_q;
    assign instruction_o = instr_q;
    assign instr_pc_o    = instr_pc_q;

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    req_pc_d = pc_addr_in;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // A kill racing the ack wins; otherwise a late ack must be absorbed in DROP.
                if (kill) begin
                    state_d = mmu.i_ack ? IDLE : DROP;
                end else if (mmu.i_ack) begin
                    instr_d    = mmu.i_paddr;
                    instr_pc_d = req_pc_q;
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end
            end
            DROP: begin
                if (mmu.i_ack) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (kill || id_ready_in) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_pc_q   <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic            fetch_evt;
    logic            kill_evt;
    logic [XLEN-1:0] fetch_cnt_q, kill_cnt_q;

    // Kills only count when they actually discard an outstanding request or a held instruction.
    assign fetch_evt = (state_q == HOLD) && !kill && id_ready_in;
    assign kill_evt  = kill && ((state_q == WAIT) || (state_q == HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (fetch_evt) fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
            if (kill_evt)  kill_cnt_q  <= kill_cnt_q + XLEN'(1);
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign kill_cnt_o  = kill_cnt_q;
`endif

endmodule
